// File: rtl/core_sequencer.sv
// core_sequencer: per-block instruction sequencer. It owns pc and the active-thread mask and gates the per-lane enables.
// Optional WAIT watchdog, enabled by defining CORE_SEQ_TIMEOUT_EN.

module core_seq_lane (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic acc,
  input  logic active,
  input  logic lsu_done,
  output logic ok
);
  logic sticky;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      sticky <= 1'b0;
    else if (clr)    sticky <= 1'b0;
    else if (acc)    sticky <= sticky | lsu_done;
  end

  // A lane counts as complete if it is inactive, or if it has seen a completion now or earlier.
  assign ok = sticky | lsu_done | ~active;
endmodule

module core_sequencer #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int TIMEOUT_CYCLES        = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [$clog2(THREADS_PER_BLOCK):0] thread_count,
  output logic                               fetch_enable,
  input  logic                               fetch_done,
  input  logic                               is_ldr,
  input  logic                               is_str,
  input  logic                               is_branch,
  input  logic                               is_cmp,
  input  logic                               is_halt,
  input  logic                               writes_reg,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0]   branch_target,
  input  logic [THREADS_PER_BLOCK-1:0]       cond_met,
  input  logic [THREADS_PER_BLOCK-1:0]       lsu_done,
  output logic [THREADS_PER_BLOCK-1:0]       lsu_enable,
  output logic [THREADS_PER_BLOCK-1:0]       reg_write_enable,
  output logic [THREADS_PER_BLOCK-1:0]       nzp_write_enable,
  output logic [THREADS_PER_BLOCK-1:0]       active_mask,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0]   pc,
  output logic [2:0]                         core_state,
  output logic                               done,
  output logic                               diverge_err,
  output logic                               timeout_err
);
  localparam int T  = THREADS_PER_BLOCK;
  localparam int AW = PROGRAM_MEM_ADDR_BITS;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_REQUEST = 3'd3,
    S_WAIT = 3'd4, S_EXECUTE = 3'd5, S_UPDATE = 3'd6, S_DONE = 3'd7
  } state_t;

  typedef struct packed {
    logic ldr;
    logic str;
    logic branch;
    logic cmp;
    logic halt;
    logic wr;
  } ctrl_t;

  state_t       state, state_nx;
  ctrl_t        ctrl_q;
  logic [T-1:0] start_mask, lane_ok, br_hit;
  logic         mem_op, wait_ok, br_uniform, br_partial, wd_fire;

  assign mem_op     = ctrl_q.ldr | ctrl_q.str;
  assign wait_ok    = ~mem_op | (&lane_ok);
  assign br_hit     = cond_met & active_mask;
  assign br_uniform = (br_hit == active_mask);
  assign br_partial = (|br_hit) & ~br_uniform;

  always_comb begin
    start_mask = '0;
    for (int i = 0; i < T; i++) start_mask[i] = (int'(thread_count) > i);
  end

  core_seq_lane u_lane [T-1:0] (
    .clk      (clk),
    .reset    (reset),
    .clr      (state == S_REQUEST && mem_op),
    .acc      (state == S_WAIT && mem_op),
    .active   (active_mask),
    .lsu_done (lsu_done),
    .ok       (lane_ok)
  );

`ifdef CORE_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        wait_cnt <= '0;
    else if (state == S_WAIT && !wait_ok) wait_cnt <= wait_cnt + CW'(1);
    else                               wait_cnt <= '0;
  end

  assign wd_fire = (state == S_WAIT) && !wait_ok && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       timeout_err <= 1'b0;
    else if (state == S_IDLE && start) timeout_err <= 1'b0;
    else if (wd_fire)                 timeout_err <= 1'b1;
  end
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start) state_nx = (thread_count == '0) ? S_DONE : S_FETCH;
      S_FETCH:   if (fetch_done) state_nx = S_DECODE;
      S_DECODE:  state_nx = S_REQUEST;
      S_REQUEST: state_nx = S_WAIT;
      S_WAIT: begin
        if (wd_fire)      state_nx = S_DONE;
        else if (wait_ok) state_nx = S_EXECUTE;
      end
      S_EXECUTE: state_nx = S_UPDATE;
      S_UPDATE:  state_nx = ctrl_q.halt ? S_DONE : S_FETCH;
      S_DONE:    if (!start) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Decoded controls are captured once per instruction, so every enable is a pure function of registered state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= '0;
      active_mask <= '0;
      diverge_err <= 1'b0;
      ctrl_q      <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          pc          <= '0;
          diverge_err <= 1'b0;
          active_mask <= start_mask;
        end
        S_DECODE: ctrl_q <= {is_ldr, is_str, is_branch, is_cmp, is_halt, writes_reg};
        S_UPDATE: if (!ctrl_q.halt) begin
          if (ctrl_q.branch && br_uniform) pc <= branch_target;
          else begin
            pc <= pc + AW'(1);
            if (ctrl_q.branch && br_partial) diverge_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_state       = state;
  assign fetch_enable     = (state == S_FETCH);
  assign done             = (state == S_DONE);
  assign lsu_enable       = (state == S_REQUEST && mem_op)    ? active_mask : '0;
  assign reg_write_enable = (state == S_UPDATE && ctrl_q.wr)  ? active_mask : '0;
  assign nzp_write_enable = (state == S_UPDATE && ctrl_q.cmp) ? active_mask : '0;
endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: directed instruction table, corner-case sequences and randomized blocks checked against a reference model.
module tb_core_sequencer;
  localparam int T   = 4;
  localparam int AW  = 8;
  localparam int TCW = $clog2(T) + 1;

  typedef struct packed {
    logic ldr, str, br, cmp, halt, wr, pulse;
    logic [7:0]      tgt;
    logic [3:0]      cond;
    logic [7:0]      f;
    logic [3:0][7:0] d;
  } instr_t;

  typedef struct packed {
    logic [7:0] pc;
    logic       div;
    logic [7:0] cyc;
    logic [3:0] rw, nzp, lsu;
    logic [2:0] st;
  } exp_t;

  typedef struct packed {
    instr_t in;
    exp_t   ex;
  } vec_t;

  logic clk, reset, start, fetch_enable, fetch_done;
  logic is_ldr, is_str, is_branch, is_cmp, is_halt, writes_reg;
  logic [TCW-1:0] thread_count;
  logic [AW-1:0]  branch_target, pc;
  logic [T-1:0]   cond_met, lsu_done, lsu_enable, reg_write_enable, nzp_write_enable, active_mask;
  logic [2:0]     core_state;
  logic           done, diverge_err, timeout_err;

  int    vectors = 0;
  int    miscompares = 0;
  string tag = "reset";
  logic [7:0]   pc_m;
  logic         div_m;
  logic [T-1:0] mask_m;

  core_sequencer #(.PROGRAM_MEM_ADDR_BITS(AW), .THREADS_PER_BLOCK(T), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
    .fetch_enable(fetch_enable), .fetch_done(fetch_done),
    .is_ldr(is_ldr), .is_str(is_str), .is_branch(is_branch), .is_cmp(is_cmp),
    .is_halt(is_halt), .writes_reg(writes_reg), .branch_target(branch_target),
    .cond_met(cond_met), .lsu_done(lsu_done), .lsu_enable(lsu_enable),
    .reg_write_enable(reg_write_enable), .nzp_write_enable(nzp_write_enable),
    .active_mask(active_mask), .pc(pc), .core_state(core_state), .done(done),
    .diverge_err(diverge_err), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s/%s: got %0h expected %0h", tag, nm, act, exp);
    end
  endtask

  function automatic instr_t mk_i(input logic ldr, str, br, cmp, halt, wr,
                                  input logic [7:0] tgt, input logic [3:0] cond,
                                  input logic [7:0] f, input logic [31:0] d, input logic pulse);
    instr_t r;
    r.ldr = ldr; r.str = str; r.br = br; r.cmp = cmp; r.halt = halt; r.wr = wr;
    r.tgt = tgt; r.cond = cond; r.f = f; r.d = d; r.pulse = pulse;
    return r;
  endfunction

  function automatic exp_t mk_e(input logic [7:0] pcv, input logic div, input logic [7:0] cyc,
                                input logic [3:0] rw, nzp, lsu, input logic [2:0] st);
    exp_t e;
    e.pc = pcv; e.div = div; e.cyc = cyc; e.rw = rw; e.nzp = nzp; e.lsu = lsu; e.st = st;
    return e;
  endfunction

  // Reference model: the sequencing rules applied one whole instruction at a time.
  task automatic model_step(input instr_t in, output exp_t e);
    int w;
    logic [T-1:0] hit;
    w = 1;
    if (in.ldr || in.str) begin
      w = 0;
      for (int i = 0; i < T; i++)
        if (mask_m[i] && int'(in.d[i]) + 1 > w) w = int'(in.d[i]) + 1;
    end
    e.cyc = 8'(int'(in.f) + 4 + w);
    e.rw  = in.wr  ? mask_m : '0;
    e.nzp = in.cmp ? mask_m : '0;
    e.lsu = (in.ldr || in.str) ? mask_m : '0;
    hit = in.cond & mask_m;
    if (in.halt) e.st = 3'd7;
    else begin
      e.st = 3'd1;
      if (in.br && hit == mask_m) pc_m = in.tgt;
      else begin
        if (in.br && hit != '0) div_m = 1'b1;
        pc_m = pc_m + 8'd1;
      end
    end
    e.pc  = pc_m;
    e.div = div_m;
  endtask

  function automatic instr_t rand_instr(input logic last);
    instr_t r;
    int kind;
    r = '0;
    kind = $urandom_range(0, 4);
    r.f = 8'($urandom_range(1, 4));
    r.tgt = 8'($urandom);
    r.cond = 4'($urandom);
    for (int i = 0; i < T; i++) r.d[i] = 8'($urandom_range(0, 5));
    r.pulse = 1'($urandom);
    case (kind)
      0: begin r.wr = 1'($urandom); r.cmp = 1'($urandom); end
      1: begin r.ldr = 1'b1; r.wr = 1'b1; end
      2: r.str = 1'b1;
      3: begin r.br = 1'b1; if ($urandom_range(0, 1) == 1) r.cond = '1; end
      default: ;
    endcase
    r.halt = last;
    return r;
  endfunction

  // Precondition: at a negedge with the DUT in IDLE. Leaves the bench at the first negedge after start is taken.
  task automatic start_block(input int tc);
    logic [T-1:0] m;
    m = (tc >= T) ? {T{1'b1}} : T'((1 << tc) - 1);
    pc_m = '0; div_m = 1'b0; mask_m = m;
    thread_count = TCW'(tc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_mask",  32'(active_mask), 32'(m));
    chk("start_pc",    32'(pc), 32'(pc_m));
    chk("start_div",   32'(diverge_err), 32'(div_m));
    chk("start_tmo",   32'(timeout_err), 32'(div_m));
    chk("start_state", 32'(core_state), (tc == 0) ? 32'd7 : 32'd1);
  endtask

  task automatic end_block();
    chk("done_flag", 32'(done), 32'd1);
    @(negedge clk);
    chk("idle_return", 32'(core_state), 32'd0);
  endtask

  // Precondition: at the negedge of the first FETCH cycle. Returns at the negedge where the next FETCH or DONE is current.
  task automatic run_instr(input instr_t in, input exp_t ex, output int cyc);
    int fc, k, lsu_n, rw_n, nzp_n;
    logic left;
    logic [T-1:0] lsu_s, rw_s, nzp_s;
    logic [2:0] st;
    fc = 0; k = -1; lsu_n = 0; rw_n = 0; nzp_n = 0; left = 1'b0; cyc = 0;
    lsu_s = '0; rw_s = '0; nzp_s = '0;
    {is_ldr, is_str, is_branch, is_cmp, is_halt, writes_reg} = {in.ldr, in.str, in.br, in.cmp, in.halt, in.wr};
    branch_target = in.tgt;
    cond_met = in.cond;
    while (1) begin
      st = core_state;
      if (left && (st == 3'd1 || st == 3'd7)) break;
      if (st != 3'd1) left = 1'b1;
      if (cyc >= 200) begin
        vectors++; miscompares++;
        $display("FAIL %s/instr_hang: state %0d after %0d cycles, expected %0d cycles", tag, st, cyc, ex.cyc);
        break;
      end
      if (st == 3'd1) begin fc++; fetch_done = (fc >= int'(in.f)); end
      else fetch_done = 1'b0;
      if (st == 3'd4) begin
        k++;
        for (int i = 0; i < T; i++)
          lsu_done[i] = in.pulse ? (k == int'(in.d[i])) : (k >= int'(in.d[i]));
      end else lsu_done = '0;
      if (lsu_enable != '0)       begin lsu_n++; lsu_s = lsu_enable; end
      if (reg_write_enable != '0) begin rw_n++;  rw_s  = reg_write_enable; end
      if (nzp_write_enable != '0) begin nzp_n++; nzp_s = nzp_write_enable; end
      @(negedge clk);
      cyc++;
    end
    fetch_done = 1'b0;
    lsu_done = '0;
    chk("cycles",    32'(cyc), 32'(ex.cyc));
    chk("pc",        32'(pc), 32'(ex.pc));
    chk("diverge",   32'(diverge_err), 32'(ex.div));
    chk("state",     32'(core_state), 32'(ex.st));
    chk("done",      32'(done), (ex.st == 3'd7) ? 32'd1 : 32'd0);
    chk("lsu_pulses", 32'(lsu_n), (ex.lsu != '0) ? 32'd1 : 32'd0);
    chk("lsu_mask",  32'(lsu_s), 32'(ex.lsu));
    chk("rw_pulses", 32'(rw_n), (ex.rw != '0) ? 32'd1 : 32'd0);
    chk("rw_mask",   32'(rw_s), 32'(ex.rw));
    chk("nzp_pulses", 32'(nzp_n), (ex.nzp != '0) ? 32'd1 : 32'd0);
    chk("nzp_mask",  32'(nzp_s), 32'(ex.nzp));
  endtask

  vec_t tbl [10];

  initial begin
    int c1, c2, n;
    reset = 1'b0; start = 1'b0; thread_count = '0; fetch_done = 1'b0;
    {is_ldr, is_str, is_branch, is_cmp, is_halt, writes_reg} = '0;
    branch_target = '0; cond_met = '0; lsu_done = '0;
    repeat (2) @(negedge clk);
    chk("state", 32'(core_state), 32'd0);
    chk("pc",    32'(pc), 32'd0);
    chk("mask",  32'(active_mask), 32'd0);
    chk("enables", 32'({lsu_enable, reg_write_enable, nzp_write_enable, fetch_enable}), 32'd0);
    chk("flags", 32'({done, diverge_err, timeout_err}), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Directed table: one 4-lane block, expectations worked out by hand.
    tbl[0].in = mk_i(0,0,0,0,0,0, 8'h00, 4'h0, 8'd1, 32'h0, 0);          tbl[0].ex = mk_e(8'h01, 0, 8'd6,  4'h0, 4'h0, 4'h0, 3'd1);
    tbl[1].in = mk_i(0,0,0,1,0,1, 8'h00, 4'h0, 8'd3, 32'h0, 0);          tbl[1].ex = mk_e(8'h02, 0, 8'd8,  4'hF, 4'hF, 4'h0, 3'd1);
    tbl[2].in = mk_i(1,0,0,0,0,1, 8'h00, 4'h0, 8'd1, 32'h06060301, 1);   tbl[2].ex = mk_e(8'h03, 0, 8'd12, 4'hF, 4'h0, 4'hF, 3'd1);
    tbl[3].in = mk_i(0,1,0,0,0,0, 8'h00, 4'h0, 8'd2, 32'h0, 0);          tbl[3].ex = mk_e(8'h04, 0, 8'd7,  4'h0, 4'h0, 4'hF, 3'd1);
    tbl[4].in = mk_i(0,0,1,0,0,0, 8'h40, 4'hF, 8'd1, 32'h0, 0);          tbl[4].ex = mk_e(8'h40, 0, 8'd6,  4'h0, 4'h0, 4'h0, 3'd1);
    tbl[5].in = mk_i(0,0,1,0,0,0, 8'h10, 4'h5, 8'd1, 32'h0, 0);          tbl[5].ex = mk_e(8'h41, 1, 8'd6,  4'h0, 4'h0, 4'h0, 3'd1);
    tbl[6].in = mk_i(0,0,1,0,0,0, 8'hFF, 4'hF, 8'd1, 32'h0, 0);          tbl[6].ex = mk_e(8'hFF, 1, 8'd6,  4'h0, 4'h0, 4'h0, 3'd1);
    tbl[7].in = mk_i(0,0,0,0,0,0, 8'h00, 4'h0, 8'd1, 32'h0, 0);          tbl[7].ex = mk_e(8'h00, 1, 8'd6,  4'h0, 4'h0, 4'h0, 3'd1);
    tbl[8].in = mk_i(0,0,1,0,0,0, 8'h20, 4'h0, 8'd1, 32'h0, 0);          tbl[8].ex = mk_e(8'h01, 1, 8'd6,  4'h0, 4'h0, 4'h0, 3'd1);
    tbl[9].in = mk_i(0,0,0,0,1,0, 8'h00, 4'h0, 8'd2, 32'h0, 0);          tbl[9].ex = mk_e(8'h01, 1, 8'd7,  4'h0, 4'h0, 4'h0, 3'd7);
    tag = "table";
    start_block(4);
    for (int i = 0; i < 10; i++) run_instr(tbl[i].in, tbl[i].ex, c1);
    end_block();

    // Three lanes, NOP then HALT: done is reached 15 cycles after start, and diverge_err from the previous block is cleared.
    tag = "tc3_halt";
    start_block(3);
    run_instr(mk_i(0,0,0,0,0,0, 8'h00, 4'h0, 8'd2, 32'h0, 0), mk_e(8'h01, 0, 8'd7, 4'h0, 4'h0, 4'h0, 3'd1), c1);
    run_instr(mk_i(0,0,0,0,1,0, 8'h00, 4'h0, 8'd2, 32'h0, 0), mk_e(8'h01, 0, 8'd7, 4'h0, 4'h0, 4'h0, 3'd7), c2);
    chk("start_to_done", 32'(1 + c1 + c2), 32'd15);
    end_block();

    // Two lanes; lsu_done never arrives on the inactive lanes.
    tag = "tc2_ldr";
    start_block(2);
    run_instr(mk_i(1,0,0,0,0,1, 8'h00, 4'h0, 8'd1, 32'hFFFF0101, 1), mk_e(8'h01, 0, 8'd7, 4'h3, 4'h0, 4'h3, 3'd1), c1);
    run_instr(mk_i(0,0,0,0,1,0, 8'h00, 4'h0, 8'd1, 32'h0, 0),        mk_e(8'h01, 0, 8'd6, 4'h0, 4'h0, 4'h0, 3'd7), c1);
    end_block();

    tag = "tc7_clamp";
    start_block(7);
    run_instr(mk_i(0,0,0,0,1,1, 8'h00, 4'h0, 8'd1, 32'h0, 0), mk_e(8'h00, 0, 8'd6, 4'hF, 4'h0, 4'h0, 3'd7), c1);
    end_block();

    tag = "tc0";
    start_block(0);
    end_block();

`ifdef CORE_SEQ_TIMEOUT_EN
    tag = "watchdog";
    start_block(4);
    run_instr(mk_i(1,0,0,0,0,1, 8'h00, 4'h0, 8'd1, 32'hFFFFFFFF, 0), mk_e(8'h00, 0, 8'd19, 4'h0, 4'h0, 4'hF, 3'd7), c1);
    chk("timeout_err", 32'(timeout_err), 32'd1);
    end_block();
`endif

    // Asynchronous reset while parked in WAIT.
    tag = "reset_in_wait";
    start_block(4);
    run_instr(mk_i(0,0,0,0,0,0, 8'h00, 4'h0, 8'd1, 32'h0, 0), mk_e(8'h01, 0, 8'd6, 4'h0, 4'h0, 4'h0, 3'd1), c1);
    is_ldr = 1'b1; writes_reg = 1'b1; is_cmp = 1'b1; lsu_done = '0; fetch_done = 1'b1;
    n = 0;
    while (core_state != 3'd4 && n < 20) begin @(negedge clk); n++; end
    fetch_done = 1'b0;
    chk("reached_wait", 32'(core_state), 32'd4);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("state", 32'(core_state), 32'd0);
    chk("pc",    32'(pc), 32'd0);
    chk("mask",  32'(active_mask), 32'd0);
    chk("enables", 32'({lsu_enable, reg_write_enable, nzp_write_enable, fetch_enable}), 32'd0);
    chk("flags", 32'({done, diverge_err, timeout_err}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_reset_quiet", 32'({core_state, lsu_enable, reg_write_enable, nzp_write_enable}), 32'd0);
    end
    {is_ldr, writes_reg, is_cmp} = '0;

    // Randomized blocks against the reference model.
    tag = "random";
    for (int b = 0; b < 30; b++) begin
      int tc, ni;
      instr_t r;
      exp_t e;
      tc = $urandom_range(0, 6);
      start_block(tc);
      if (tc != 0) begin
        ni = $urandom_range(1, 6);
        for (int j = 0; j < ni; j++) begin
          r = rand_instr(j == ni - 1);
          model_step(r, e);
          run_instr(r, e, c1);
        end
      end
      end_block();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/core_sequencer.md
# core_sequencer

Per-block control FSM for the next-generation compute core. It sequences each instruction through FETCH, DECODE, REQUEST, WAIT, EXECUTE and UPDATE, and owns the program counter and the runtime active-thread mask. It gates the per-thread LSU, register-file and NZP enables, resolves uniform branches and detects branch divergence. It sits between the fetch unit and decoder on one side and the THREADS_PER_BLOCK-wide register/ALU/LSU lanes on the other.

## Interface
- PROGRAM_MEM_ADDR_BITS, 8, PC width
- THREADS_PER_BLOCK, 4, lane count (≥1)
- TIMEOUT_CYCLES, 64, WAIT watchdog limit (used only with CORE_SEQ_TIMEOUT_EN)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  begin block execution
- thread_count  in  $clog2(THREADS_PER_BLOCK)+1  active threads this block
- fetch_enable  out  1  request instruction fetch
- fetch_done  in  1  instruction valid
- is_ldr, is_str, is_branch, is_cmp, is_halt, writes_reg  in  1 each  decoded controls
- branch_target  in  PROGRAM_MEM_ADDR_BITS  branch destination
- cond_met  in  THREADS_PER_BLOCK  per-lane NZP condition match
- lsu_done  in  THREADS_PER_BLOCK  per-lane LSU completion
- lsu_enable  out  THREADS_PER_BLOCK  per-lane LSU request pulse
- reg_write_enable  out  THREADS_PER_BLOCK  per-lane register write
- nzp_write_enable  out  THREADS_PER_BLOCK  per-lane NZP update
- active_mask  out  THREADS_PER_BLOCK  latched lane mask
- pc  out  PROGRAM_MEM_ADDR_BITS  program counter
- core_state  out  3  current state
- done  out  1  block finished
- diverge_err  out  1  sticky divergence flag
- timeout_err  out  1  sticky watchdog flag

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7.
- IDLE, start=1:
  - Clear pc, diverge_err and timeout_err.
  - Latch active_mask with bits [min(thread_count,T)-1:0] set.
  - thread_count=0 goes to DONE; otherwise go to FETCH.
- start is ignored outside IDLE.
- FETCH: hold fetch_enable=1. Move to DECODE in the cycle fetch_done=1 is sampled.
- DECODE: one cycle, then REQUEST.
- REQUEST: one cycle. If is_ldr|is_str, set lsu_enable=active_mask for this cycle only and clear the sticky done vector. Then WAIT.
- WAIT:
  - Not a memory op: one cycle.
  - Memory op: OR lsu_done into the sticky vector each cycle. Leave when (sticky | lsu_done | ~active_mask) is all ones.
  - Next state is EXECUTE.
- EXECUTE: one cycle (lanes' ALUs settle), then UPDATE.
- UPDATE, one cycle:
  - reg_write_enable=active_mask if writes_reg.
  - nzp_write_enable=active_mask if is_cmp.
  - If is_halt, go to DONE with pc unchanged.
  - Else if is_branch and (cond_met & active_mask)==active_mask, set pc=branch_target.
  - Else if is_branch and (cond_met & active_mask) is nonzero but not all active lanes, set diverge_err=1 and pc=pc+1.
  - Otherwise pc=pc+1, modulo 2^PROGRAM_MEM_ADDR_BITS, so the maximum address wraps to 0.
  - Non-halt then goes to FETCH.
- DONE: done=1. Return to IDLE when start=0.
- Reset values (asynchronous, reset=0): core_state=IDLE, pc=0, active_mask=0, all enables 0, done=0, diverge_err=0, timeout_err=0, sticky vector 0.
- Reset mid-instruction aborts the instruction: no enable pulse is emitted after reset asserts.

## Timing
- All outputs are registered state or decoded from core_state only; there are no input-to-output combinational paths.
- Let f≥1 be the number of FETCH cycles including the one where fetch_done is sampled.
- Non-memory instruction: f+5 cycles from FETCH entry to the next FETCH or DONE entry.
- Memory instruction: f+4+w cycles, where w≥1 is the number of WAIT cycles.
- lsu_done may be a pulse or a level; either completes its lane.
- done asserts one cycle after the UPDATE that decodes is_halt.

## Configuration
- CORE_SEQ_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - At TIMEOUT_CYCLES consecutive WAIT cycles without completion, go to DONE with timeout_err=1 and no register write.
- CORE_SEQ_TIMEOUT_EN undefined: no counter. WAIT blocks indefinitely. timeout_err is tied to 0.

## Test plan
- thread_count=3, program NOP@0, HALT@1, fetch_done after 2 cycles -> active_mask=0111, pc 0→1, done=1 after 15 cycles from start, no reg_write_enable pulse.
- thread_count=4, LDR with lsu_done lane0 at WAIT+1, lane1 at WAIT+3, lane2/3 at WAIT+6 -> EXECUTE entered only after WAIT+6; reg_write_enable=1111 for exactly one cycle.
- thread_count=2, lsu_done never for lane3 (inactive), lanes0/1 at WAIT+1 -> no hang; lsu_enable=0011 pulse.
- Branch target=0x40 with cond_met=1111 on 4 lanes -> pc=0x40. With cond_met=0101 -> pc=pc+1 and diverge_err=1 held until the next start.
- pc=0xFF non-branch -> pc=0x00. thread_count=7 with T=4 -> active_mask=1111. thread_count=0 -> done after 1 cycle.
- reset=0 during WAIT -> all outputs at reset values immediately. With CORE_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, lsu_done stuck 0 -> DONE after 16 WAIT cycles, timeout_err=1.
